// File: rtl/ex_issue_stage_pkg.sv
// Shared encodings for the EX issue stage: ALU op codes, aluop classes,
// instruction opcodes and the zero-register index.
package ex_issue_stage_pkg;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_ORR   = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_SUB   = 4'b0110,
    ALU_PASSB = 4'b0111,
    ALU_NOR   = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    ALUOP_MEM   = 2'b00,
    ALUOP_CBZ   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ITYPE = 2'b11
  } aluop_e;

  localparam logic [10:0] OPC_ADD = 11'b10001011000;
  localparam logic [10:0] OPC_SUB = 11'b11001011000;
  localparam logic [10:0] OPC_AND = 11'b10001010000;
  localparam logic [10:0] OPC_ORR = 11'b10101010000;

  // I-type opcodes are 10 bits wide; instruction bit 21 is part of the immediate.
  localparam logic [9:0] OPC_ADDI = 10'b1001000100;
  localparam logic [9:0] OPC_SUBI = 10'b1101000100;
  localparam logic [9:0] OPC_ANDI = 10'b1001001000;
  localparam logic [9:0] OPC_ORRI = 10'b1011001000;

  localparam int unsigned XZR = 31;

  typedef struct packed {
    logic    illegal;
    alu_op_e op;
  } op_dec_t;

endpackage

// File: rtl/ex_issue_stage_fwd_mux.sv
// Operand forwarding select for one source register: EX/MEM beats MEM/WB,
// which beats the latched register-file value; XZR is never forwarded.
module fwd_mux
  import ex_issue_stage_pkg::*;
#(
  parameter int N  = 64,
  parameter int RW = 5
) (
  input  logic [RW-1:0] src_idx,
  input  logic [N-1:0]  src_data,
  input  logic          mem_regwrite,
  input  logic [RW-1:0] mem_rd,
  input  logic [N-1:0]  mem_result,
  input  logic          wb_regwrite,
  input  logic [RW-1:0] wb_rd,
  input  logic [N-1:0]  wb_result,
  output logic [N-1:0]  fwd_data
);

  localparam logic [RW-1:0] XZR_IDX = RW'(XZR);

  logic not_xzr;
  assign not_xzr = (src_idx != XZR_IDX);

  always_comb begin
    fwd_data = src_data;
    if (mem_regwrite && (mem_rd == src_idx) && not_xzr) begin
      fwd_data = mem_result;
    end else if (wb_regwrite && (wb_rd == src_idx) && not_xzr) begin
      fwd_data = wb_result;
    end
  end

endmodule

// File: rtl/ex_issue_stage.sv
// ID/EX pipeline register with ALU op decode, operand forwarding into the ALU
// and the load-use stall request.
module ex_issue_stage
  import ex_issue_stage_pkg::*;
#(
  parameter int N  = 64,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic          id_stall,
  input  logic          id_flush,
  input  logic [RW-1:0] id_rs1,
  input  logic [RW-1:0] id_rs2,
  input  logic [RW-1:0] id_rd,
  input  logic [N-1:0]  id_rdata1,
  input  logic [N-1:0]  id_rdata2,
  input  logic [N-1:0]  id_imm,
  input  logic          id_alusrc,
  input  logic [1:0]    id_aluop,
  input  logic [10:0]   id_opcode,
  input  logic          id_memread,
  input  logic          id_memwrite,
  input  logic          id_regwrite,
  input  logic          mem_regwrite,
  input  logic [RW-1:0] mem_rd,
  input  logic [N-1:0]  mem_result,
  input  logic          wb_regwrite,
  input  logic [RW-1:0] wb_rd,
  input  logic [N-1:0]  wb_result,
  output logic          ex_valid,
  output logic [N-1:0]  alu_a,
  output logic [N-1:0]  alu_b,
  output logic [3:0]    alu_op,
  output logic [N-1:0]  ex_store_data,
  output logic [RW-1:0] ex_rd,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_regwrite,
  output logic          ex_illegal,
  output logic          stall_req
);

  localparam logic [RW-1:0] XZR_IDX = RW'(XZR);

  function automatic op_dec_t decode_op(input logic [1:0] aluop, input logic [10:0] opcode);
    op_dec_t d;
    d.illegal = 1'b0;
    d.op      = ALU_ADD;
    case (aluop)
      ALUOP_MEM: d.op = ALU_ADD;
      ALUOP_CBZ: d.op = ALU_PASSB;
      ALUOP_RTYPE: begin
        case (opcode)
          OPC_ADD: d.op = ALU_ADD;
          OPC_SUB: d.op = ALU_SUB;
          OPC_AND: d.op = ALU_AND;
          OPC_ORR: d.op = ALU_ORR;
          default: d.illegal = 1'b1;
        endcase
      end
      default: begin
        case (opcode[10:1])
          OPC_ADDI: d.op = ALU_ADD;
          OPC_SUBI: d.op = ALU_SUB;
          OPC_ANDI: d.op = ALU_AND;
          OPC_ORRI: d.op = ALU_ORR;
          default:  d.illegal = 1'b1;
        endcase
      end
    endcase
    return d;
  endfunction

  op_dec_t id_dec;
  assign id_dec = decode_op(id_aluop, id_opcode);

  logic          vld_p1;
  logic [RW-1:0] rs1_p1;
  logic [RW-1:0] rs2_p1;
  logic [RW-1:0] rd_p1;
  logic [N-1:0]  rdata1_p1;
  logic [N-1:0]  rdata2_p1;
  logic [N-1:0]  imm_p1;
  logic          alusrc_p1;
  alu_op_e       op_p1;
  logic          memread_p1;
  logic          memwrite_p1;
  logic          regwrite_p1;
  logic          illegal_p1;

  // ---- ID -> EX boundary ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      memread_p1  <= 1'b0;
      memwrite_p1 <= 1'b0;
      regwrite_p1 <= 1'b0;
      illegal_p1  <= 1'b0;
      op_p1       <= ALU_ADD;
      rd_p1       <= '0;
      rs1_p1      <= '0;
      rs2_p1      <= '0;
      rdata1_p1   <= '0;
      rdata2_p1   <= '0;
      imm_p1      <= '0;
      alusrc_p1   <= 1'b0;
    end else if (id_flush) begin
      // Bubble: park sources on XZR so nothing can be forwarded into it.
      vld_p1      <= 1'b0;
      memread_p1  <= 1'b0;
      memwrite_p1 <= 1'b0;
      regwrite_p1 <= 1'b0;
      illegal_p1  <= 1'b0;
      op_p1       <= ALU_ADD;
      rd_p1       <= '0;
      rs1_p1      <= XZR_IDX;
      rs2_p1      <= XZR_IDX;
      rdata1_p1   <= '0;
      rdata2_p1   <= '0;
      imm_p1      <= '0;
      alusrc_p1   <= 1'b0;
    end else if (!id_stall) begin
      vld_p1      <= id_valid;
      memread_p1  <= id_memread & id_valid;
      memwrite_p1 <= id_memwrite & id_valid;
      regwrite_p1 <= id_regwrite & id_valid;
      illegal_p1  <= id_dec.illegal & id_valid;
      op_p1       <= id_dec.op;
      rd_p1       <= id_rd;
      rs1_p1      <= id_rs1;
      rs2_p1      <= id_rs2;
      rdata1_p1   <= id_rdata1;
      rdata2_p1   <= id_rdata2;
      imm_p1      <= id_imm;
      alusrc_p1   <= id_alusrc;
    end
  end

  logic [N-1:0] fwd1;
  logic [N-1:0] fwd2;

  fwd_mux #(.N(N), .RW(RW)) u_fwd_rs1 (
    .src_idx      (rs1_p1),
    .src_data     (rdata1_p1),
    .mem_regwrite (mem_regwrite),
    .mem_rd       (mem_rd),
    .mem_result   (mem_result),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .wb_result    (wb_result),
    .fwd_data     (fwd1)
  );

  fwd_mux #(.N(N), .RW(RW)) u_fwd_rs2 (
    .src_idx      (rs2_p1),
    .src_data     (rdata2_p1),
    .mem_regwrite (mem_regwrite),
    .mem_rd       (mem_rd),
    .mem_result   (mem_result),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .wb_result    (wb_result),
    .fwd_data     (fwd2)
  );

  assign alu_a         = fwd1;
  assign alu_b         = alusrc_p1 ? imm_p1 : fwd2;
  assign ex_store_data = fwd2;
  assign alu_op        = op_p1;
  assign ex_valid      = vld_p1;
  assign ex_rd         = rd_p1;
  assign ex_memread    = memread_p1;
  assign ex_memwrite   = memwrite_p1;
  assign ex_regwrite   = regwrite_p1;
  assign ex_illegal    = illegal_p1;

  // A load in EX feeding an ID source cannot be forwarded in time; rs2 only
  // matters when it actually reaches the ALU.
  assign stall_req = vld_p1 & memread_p1 & (rd_p1 != XZR_IDX) & id_valid &
                     ((rd_p1 == id_rs1) | ((rd_p1 == id_rs2) & ~id_alusrc));

endmodule

// File: tb/tb_ex_issue_stage.sv
// Bench for ex_issue_stage: directed scenarios plus randomized traffic against
// a behavioural model of the ID/EX register and forwarding rules.
module tb_ex_issue_stage;

  localparam int N  = 64;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_stall, id_flush;
  logic [RW-1:0] id_rs1, id_rs2, id_rd;
  logic [N-1:0]  id_rdata1, id_rdata2, id_imm;
  logic          id_alusrc;
  logic [1:0]    id_aluop;
  logic [10:0]   id_opcode;
  logic          id_memread, id_memwrite, id_regwrite;
  logic          mem_regwrite, wb_regwrite;
  logic [RW-1:0] mem_rd, wb_rd;
  logic [N-1:0]  mem_result, wb_result;
  logic          ex_valid;
  logic [N-1:0]  alu_a, alu_b, ex_store_data;
  logic [3:0]    alu_op;
  logic [RW-1:0] ex_rd;
  logic          ex_memread, ex_memwrite, ex_regwrite, ex_illegal, stall_req;

  always #5 clk = ~clk;

  ex_issue_stage #(.N(N), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_stall(id_stall), .id_flush(id_flush),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_alusrc(id_alusrc), .id_aluop(id_aluop), .id_opcode(id_opcode),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_regwrite(id_regwrite),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
    .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_regwrite(ex_regwrite),
    .ex_illegal(ex_illegal), .stall_req(stall_req)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model of the instruction currently sitting in EX.
  logic        m_valid = 1'b0, m_mr = 1'b0, m_mw = 1'b0, m_rw = 1'b0, m_ill = 1'b0;
  logic [3:0]  m_op = 4'b0010;
  logic [4:0]  m_rs1 = '0, m_rs2 = '0, m_rd = '0;
  logic [63:0] m_d1 = '0, m_d2 = '0, m_imm = '0;
  logic        m_alusrc = 1'b0;

  function automatic logic [4:0] ref_decode(input logic [1:0] aluop, input logic [10:0] opc);
    logic [9:0] hi;
    hi = opc[10:1];
    if (aluop == 2'b00) return 5'b0_0010;
    if (aluop == 2'b01) return 5'b0_0111;
    if (aluop == 2'b10) begin
      if (opc == 11'b10001011000) return 5'b0_0010;
      if (opc == 11'b11001011000) return 5'b0_0110;
      if (opc == 11'b10001010000) return 5'b0_0000;
      if (opc == 11'b10101010000) return 5'b0_0001;
      return 5'b1_0010;
    end
    if (hi == 10'b1001000100) return 5'b0_0010;
    if (hi == 10'b1101000100) return 5'b0_0110;
    if (hi == 10'b1001001000) return 5'b0_0000;
    if (hi == 10'b1011001000) return 5'b0_0001;
    return 5'b1_0010;
  endfunction

  function automatic logic [63:0] ref_fwd(input logic [4:0] idx, input logic [63:0] d);
    if (idx == 5'd31) return d;
    if (mem_regwrite && mem_rd == idx) return mem_result;
    if (wb_regwrite && wb_rd == idx) return wb_result;
    return d;
  endfunction

  task automatic model_update();
    logic [4:0] dec;
    if (!rst_n) begin
      m_valid = 0; m_mr = 0; m_mw = 0; m_rw = 0; m_ill = 0; m_op = 4'b0010;
      m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_d1 = 0; m_d2 = 0; m_imm = 0; m_alusrc = 0;
    end else if (id_flush) begin
      m_valid = 0; m_mr = 0; m_mw = 0; m_rw = 0; m_ill = 0; m_op = 4'b0010;
    end else if (!id_stall) begin
      dec      = ref_decode(id_aluop, id_opcode);
      m_valid  = id_valid;
      m_mr     = id_memread & id_valid;
      m_mw     = id_memwrite & id_valid;
      m_rw     = id_regwrite & id_valid;
      m_ill    = dec[4] & id_valid;
      m_op     = dec[3:0];
      m_rs1    = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
      m_d1     = id_rdata1; m_d2 = id_rdata2; m_imm = id_imm;
      m_alusrc = id_alusrc;
    end
  endtask

  task automatic check_all();
    logic exp_stall;
    logic [63:0] f2;
    exp_stall = m_valid && m_mr && (m_rd != 5'd31) && id_valid &&
                ((m_rd == id_rs1) || ((m_rd == id_rs2) && !id_alusrc));
    check("ex_valid", 64'(ex_valid), 64'(m_valid));
    check("alu_op", 64'(alu_op), 64'(m_op));
    check("ex_memread", 64'(ex_memread), 64'(m_mr));
    check("ex_memwrite", 64'(ex_memwrite), 64'(m_mw));
    check("ex_regwrite", 64'(ex_regwrite), 64'(m_rw));
    check("ex_illegal", 64'(ex_illegal), 64'(m_ill));
    check("stall_req", 64'(stall_req), 64'(exp_stall));
    if (m_valid) begin
      f2 = ref_fwd(m_rs2, m_d2);
      check("alu_a", alu_a, ref_fwd(m_rs1, m_d1));
      check("alu_b", alu_b, m_alusrc ? m_imm : f2);
      check("store_data", ex_store_data, f2);
      check("ex_rd", 64'(ex_rd), 64'(m_rd));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic probe();
    #1;
    check_all();
  endtask

  task automatic idle();
    rst_n = 1; id_valid = 0; id_stall = 0; id_flush = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rdata1 = 0; id_rdata2 = 0; id_imm = 0;
    id_alusrc = 0; id_aluop = 0; id_opcode = 0;
    id_memread = 0; id_memwrite = 0; id_regwrite = 0;
    mem_regwrite = 0; mem_rd = 0; mem_result = 0;
    wb_regwrite = 0; wb_rd = 0; wb_result = 0;
  endtask

  function automatic logic [4:0] pick_reg();
    if ($urandom_range(0, 3) == 0) return 5'd31;
    return 5'($urandom_range(0, 7));
  endfunction

  task automatic rand_inputs();
    rst_n       = ($urandom_range(0, 99) != 0);
    id_valid    = ($urandom_range(0, 3) != 0);
    id_stall    = ($urandom_range(0, 5) == 0);
    id_flush    = ($urandom_range(0, 7) == 0);
    id_rs1      = pick_reg();
    id_rs2      = pick_reg();
    id_rd       = pick_reg();
    id_rdata1   = {$urandom(), $urandom()};
    id_rdata2   = {$urandom(), $urandom()};
    id_imm      = {$urandom(), $urandom()};
    id_alusrc   = 1'($urandom_range(0, 1));
    id_aluop    = 2'($urandom_range(0, 3));
    case ($urandom_range(0, 9))
      0: id_opcode = 11'b10001011000;
      1: id_opcode = 11'b11001011000;
      2: id_opcode = 11'b10001010000;
      3: id_opcode = 11'b10101010000;
      4: id_opcode = {10'b1001000100, 1'($urandom_range(0, 1))};
      5: id_opcode = {10'b1101000100, 1'($urandom_range(0, 1))};
      6: id_opcode = {10'b1001001000, 1'($urandom_range(0, 1))};
      7: id_opcode = {10'b1011001000, 1'($urandom_range(0, 1))};
      default: id_opcode = 11'($urandom());
    endcase
    id_memread   = 1'($urandom_range(0, 1));
    id_memwrite  = 1'($urandom_range(0, 1));
    id_regwrite  = 1'($urandom_range(0, 1));
    mem_regwrite = 1'($urandom_range(0, 1));
    mem_rd       = pick_reg();
    mem_result   = {$urandom(), $urandom()};
    wb_regwrite  = 1'($urandom_range(0, 1));
    wb_rd        = pick_reg();
    wb_result    = {$urandom(), $urandom()};
  endtask

  initial begin
    idle();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1; id_stall = 1;
    tick();
    probe();
    check("rst_valid", 64'(ex_valid), 64'd0);
    check("rst_op", 64'(alu_op), 64'd2);
    check("rst_regwrite", 64'(ex_regwrite), 64'd0);
    check("rst_alu_a", alu_a, 64'd0);
    check("rst_rd", 64'(ex_rd), 64'd0);

    // R-type SUB
    id_stall = 0; id_valid = 1; id_rs1 = 1; id_rs2 = 2; id_rd = 3;
    id_rdata1 = 64'd10; id_rdata2 = 64'd3; id_opcode = 11'b11001011000;
    id_aluop = 2'b10; id_alusrc = 0; id_regwrite = 1;
    tick();
    id_stall = 1; id_valid = 0;
    probe();
    check("sub_op", 64'(alu_op), 64'h6);
    check("sub_a", alu_a, 64'd10);
    check("sub_b", alu_b, 64'd3);

    // Forwarding priority
    id_stall = 0; id_valid = 1; id_rs1 = 5; id_rdata1 = 64'h11; id_rs2 = 6;
    id_rdata2 = 64'h22; id_opcode = 11'b10001011000;
    tick();
    id_stall = 1;
    mem_regwrite = 1; mem_rd = 5; mem_result = 64'hAA;
    wb_regwrite = 1; wb_rd = 5; wb_result = 64'hBB;
    probe();
    check("fwd_mem", alu_a, 64'hAA);
    mem_regwrite = 0;
    probe();
    check("fwd_wb", alu_a, 64'hBB);
    id_stall = 0; id_rs1 = 31; id_rdata1 = 64'h55;
    mem_regwrite = 1; mem_rd = 31; wb_rd = 31;
    tick();
    id_stall = 1;
    probe();
    check("fwd_xzr", alu_a, 64'h55);

    // Load-use hazard
    mem_regwrite = 0; wb_regwrite = 0;
    id_stall = 0; id_valid = 1; id_rs1 = 1; id_rs2 = 2; id_rd = 7;
    id_aluop = 2'b00; id_alusrc = 1; id_imm = 64'h40;
    id_memread = 1; id_regwrite = 1; id_memwrite = 0;
    tick();
    id_stall = 1; id_rs1 = 0; id_rs2 = 7; id_alusrc = 0;
    probe();
    check("ldu_stall", 64'(stall_req), 64'd1);
    id_alusrc = 1;
    probe();
    check("ldu_nostall", 64'(stall_req), 64'd0);

    // Stall holds for three cycles
    for (int i = 0; i < 3; i++) begin
      id_rdata1 = {$urandom(), $urandom()};
      id_imm = {$urandom(), $urandom()};
      id_rd = 5'($urandom_range(0, 6));
      tick();
      probe();
      check("hold_b", alu_b, 64'h40);
      check("hold_rd", 64'(ex_rd), 64'd7);
      check("hold_mr", 64'(ex_memread), 64'd1);
      check("hold_valid", 64'(ex_valid), 64'd1);
    end
    id_flush = 1;
    tick();
    id_flush = 0;
    probe();
    check("flush_valid", 64'(ex_valid), 64'd0);
    check("flush_mr", 64'(ex_memread), 64'd0);

    // Illegal I-type opcode
    id_stall = 0; id_valid = 1; id_aluop = 2'b11; id_opcode = 11'b11111111110;
    tick();
    id_stall = 1;
    probe();
    check("ill_flag", 64'(ex_illegal), 64'd1);
    check("ill_op", 64'(alu_op), 64'd2);
    id_stall = 0; id_valid = 0;
    tick();
    id_stall = 1;
    probe();
    check("ill_invalid", 64'(ex_illegal), 64'd0);

    for (int i = 0; i < 1000; i++) begin
      rand_inputs();
      probe();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ex_issue_stage.md
Name: ex_issue_stage

Overview:
- ID/EX pipeline register plus operand-forwarding logic for the 64-bit LEGv8-style core.
- Sits directly upstream of the ALU and drives its A, B and 4-bit Op inputs.
- Latches decoded operands and control on each clock.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages.
- Raises a load-use stall request to the hazard/fetch logic.

Parameters:
- N, 64, datapath width of operands, immediate and forwarded results.
- RW, 5, register index width; index 31 (XZR) is never forwarded.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- id_valid  in  1  ID stage presents a valid instruction.
- id_stall  in  1  hold all ID/EX contents this cycle.
- id_flush  in  1  load a bubble this cycle.
- id_rs1, id_rs2, id_rd  in  RW each  source and destination register indices.
- id_rdata1, id_rdata2  in  N  register-file read data.
- id_imm  in  N  sign-extended immediate.
- id_alusrc  in  1  1 selects the immediate as B.
- id_aluop  in  2  00 add (load/store), 01 pass-B (CBZ), 10 R-type, 11 I-type.
- id_opcode  in  11  instruction[31:21].
- id_memread, id_memwrite, id_regwrite  in  1  control bits carried forward.
- mem_regwrite  in  1, mem_rd  in RW, mem_result  in N  EX/MEM forwarding source.
- wb_regwrite  in  1, wb_rd  in RW, wb_result  in N  MEM/WB forwarding source.
- ex_valid  out  1  EX holds a real instruction.
- alu_a, alu_b  out  N  forwarded ALU operands (combinational from registered state and forwarding inputs).
- alu_op  out  4  registered ALU operation code.
- ex_store_data  out  N  forwarded rs2 value for stores.
- ex_rd  out  RW, ex_memread, ex_memwrite, ex_regwrite  out  1  registered control.
- ex_illegal  out  1  registered: opcode not decodable for the given aluop.
- stall_req  out  1  combinational load-use hazard request.

Behaviour:
- Reset (rst_n=0 at edge): ex_valid, ex_memread, ex_memwrite, ex_regwrite and ex_illegal = 0; alu_op = 4'b0010; ex_rd = 0; all latched data = 0. Reset overrides stall and flush.
- Priority each edge: reset > flush > stall > load.
- Flush: valid and all control bits cleared, alu_op = 0010. Data fields may hold stale values but must not affect outputs while ex_valid = 0.
- Stall: every register holds its value.
- Load: capture all id_* fields. ex_valid = id_valid. Control bits are ANDed with id_valid.
- Op decode at load time:
  - aluop 00 -> 0010.
  - aluop 01 -> 0111.
  - aluop 10, exact 11-bit match: ADD 10001011000 -> 0010, SUB 11001011000 -> 0110, AND 10001010000 -> 0000, ORR 10101010000 -> 0001.
  - aluop 11, match on opcode[10:1]: ADDI 1001000100 -> 0010, SUBI 1101000100 -> 0110, ANDI 1001001000 -> 0000, ORRI 1011001000 -> 0001.
  - Unmatched opcode -> op 0010 and ex_illegal = 1 (only when id_valid).
- Forwarding for operand X in {rs1, rs2}:
  - If mem_regwrite and mem_rd == X and X != 31, use mem_result.
  - Else if wb_regwrite and wb_rd == X and X != 31, use wb_result.
  - Else use the latched register data.
  - EX/MEM always wins over MEM/WB.
- Operand outputs:
  - alu_a = forwarded rs1.
  - alu_b = latched imm if alusrc = 1, else forwarded rs2.
  - ex_store_data = forwarded rs2 regardless of alusrc.
- stall_req = ex_valid & ex_memread & ex_rd != 31 & id_valid & (ex_rd == id_rs1 | (ex_rd == id_rs2 & !id_alusrc)). The external hazard logic answers with id_flush for one cycle (bubble) while holding IF/ID.
- Latency: one cycle from ID to ALU inputs. The forwarding path adds no cycles.
- Width: no arithmetic is performed here. The immediate is passed through unmodified.

Decomposition:
- Shared package holds the ALU op codes (AND 0000, ORR 0001, ADD 0010, SUB 0110, PASSB 0111, NOR 1100), the aluop encodings, the opcode constants and XZR = 31.
- One natural sub-module: fwd_mux. It is instantiated twice (rs1, rs2) and takes the index, latched data and both forwarding sources.

Test Plan:
- Reset with rst_n=0 for 2 cycles, then id_stall=1 -> ex_valid=0, alu_op=0010, ex_regwrite=0.
- R-type SUB: rdata1=10, rdata2=3, opcode 11001011000, aluop 10 -> next cycle alu_op=0110, alu_a=10, alu_b=3.
- Forward priority: ex rs1=5, mem_rd=5 result 0xAA, wb_rd=5 result 0xBB, both regwrite -> alu_a=0xAA. Drop mem_regwrite -> alu_a=0xBB. Set rs1=31 -> latched value returned.
- Load-use: EX holds LDUR (memread, rd=7); ID has rs2=7 with alusrc=0 -> stall_req=1. The same case with alusrc=1 gives stall_req=0.
- Stall then flush: stall held 3 cycles -> outputs unchanged. Stall and flush together -> ex_valid=0 next cycle.
- Illegal ADDI-class opcode 11111111110 with aluop 11 -> ex_illegal=1, alu_op=0010. The same opcode with id_valid=0 -> ex_illegal=0.
